// File: rtl/noc_pkg.sv
// Shared constants and types for the 2x2 wormhole NoC.
package noc_pkg;

  localparam int unsigned NOC_NODES      = 4;
  localparam int unsigned DEST_LSB       = 0;
  localparam int unsigned DEST_W         = 2;
  localparam int unsigned NOC_DATA_WIDTH = 32;

  // Node ID = 2*X + Y
  localparam logic [DEST_W-1:0] NODE_ID_0_0 = 2'd0;
  localparam logic [DEST_W-1:0] NODE_ID_0_1 = 2'd1;
  localparam logic [DEST_W-1:0] NODE_ID_1_0 = 2'd2;
  localparam logic [DEST_W-1:0] NODE_ID_1_1 = 2'd3;

  // Flit record at the codebase default width; the connector rebuilds the
  // same layout at its own DATA_WIDTH.
  typedef struct packed {
    logic                      is_header;
    logic                      is_tail;
    logic [NOC_DATA_WIDTH-1:0] data;
  } noc_flit_t;

  typedef enum logic {StIdle, StLocked} lock_state_e;

  // Round-robin successor; wraps naturally over the 4 nodes.
  function automatic logic [DEST_W-1:0] rr_next(input logic [DEST_W-1:0] idx);
    return idx + DEST_W'(1);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with asynchronous active-low reset.
// DEPTH must be a power of two and at least 2.
module noc_flit_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_connector.sv
// 2x2 wormhole NoC connector: one ingress FIFO per node, per-output
// round-robin allocation and lock held from header to tail.
module noc_connector
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  // node 0_0
  input  logic                  Noc_0_0_receive_valid,
  output logic                  Noc_0_0_receive_ready,
  input  logic [DATA_WIDTH-1:0] Noc_0_0_receive_flit,
  input  logic                  Noc_0_0_receive_is_header,
  input  logic                  Noc_0_0_receive_is_tail,
  output logic                  Noc_0_0_sender_valid,
  input  logic                  Noc_0_0_sender_ready,
  output logic [DATA_WIDTH-1:0] Noc_0_0_sender_flit,
  output logic                  Noc_0_0_sender_is_header,
  output logic                  Noc_0_0_sender_is_tail,
  // node 0_1
  input  logic                  Noc_0_1_receive_valid,
  output logic                  Noc_0_1_receive_ready,
  input  logic [DATA_WIDTH-1:0] Noc_0_1_receive_flit,
  input  logic                  Noc_0_1_receive_is_header,
  input  logic                  Noc_0_1_receive_is_tail,
  output logic                  Noc_0_1_sender_valid,
  input  logic                  Noc_0_1_sender_ready,
  output logic [DATA_WIDTH-1:0] Noc_0_1_sender_flit,
  output logic                  Noc_0_1_sender_is_header,
  output logic                  Noc_0_1_sender_is_tail,
  // node 1_0
  input  logic                  Noc_1_0_receive_valid,
  output logic                  Noc_1_0_receive_ready,
  input  logic [DATA_WIDTH-1:0] Noc_1_0_receive_flit,
  input  logic                  Noc_1_0_receive_is_header,
  input  logic                  Noc_1_0_receive_is_tail,
  output logic                  Noc_1_0_sender_valid,
  input  logic                  Noc_1_0_sender_ready,
  output logic [DATA_WIDTH-1:0] Noc_1_0_sender_flit,
  output logic                  Noc_1_0_sender_is_header,
  output logic                  Noc_1_0_sender_is_tail,
  // node 1_1
  input  logic                  Noc_1_1_receive_valid,
  output logic                  Noc_1_1_receive_ready,
  input  logic [DATA_WIDTH-1:0] Noc_1_1_receive_flit,
  input  logic                  Noc_1_1_receive_is_header,
  input  logic                  Noc_1_1_receive_is_tail,
  output logic                  Noc_1_1_sender_valid,
  input  logic                  Noc_1_1_sender_ready,
  output logic [DATA_WIDTH-1:0] Noc_1_1_sender_flit,
  output logic                  Noc_1_1_sender_is_header,
  output logic                  Noc_1_1_sender_is_tail
);

  localparam int unsigned FW = DATA_WIDTH + 2;

  typedef struct packed {
    logic                  is_header;
    logic                  is_tail;
    logic [DATA_WIDTH-1:0] data;
  } flit_t;

  logic [NOC_NODES-1:0] in_valid, in_ready, in_full, in_empty, in_pop;
  logic [NOC_NODES-1:0] out_valid, out_ready, hs, bound;
  flit_t                in_flit  [NOC_NODES];
  flit_t                head     [NOC_NODES];
  flit_t                out_flit [NOC_NODES];

  lock_state_e          state_q  [NOC_NODES];
  logic [DEST_W-1:0]    owner_q  [NOC_NODES];
  logic [DEST_W-1:0]    rr_q     [NOC_NODES];
  logic [NOC_NODES-1:0] req      [NOC_NODES];
  logic [NOC_NODES-1:0] grant_valid;
  logic [DEST_W-1:0]    grant_idx [NOC_NODES];
  logic                 alive_q;

  // ---- port to array mapping ----
  assign in_valid[NODE_ID_0_0] = Noc_0_0_receive_valid;
  assign in_valid[NODE_ID_0_1] = Noc_0_1_receive_valid;
  assign in_valid[NODE_ID_1_0] = Noc_1_0_receive_valid;
  assign in_valid[NODE_ID_1_1] = Noc_1_1_receive_valid;

  assign in_flit[NODE_ID_0_0] = {Noc_0_0_receive_is_header, Noc_0_0_receive_is_tail,
                                 Noc_0_0_receive_flit};
  assign in_flit[NODE_ID_0_1] = {Noc_0_1_receive_is_header, Noc_0_1_receive_is_tail,
                                 Noc_0_1_receive_flit};
  assign in_flit[NODE_ID_1_0] = {Noc_1_0_receive_is_header, Noc_1_0_receive_is_tail,
                                 Noc_1_0_receive_flit};
  assign in_flit[NODE_ID_1_1] = {Noc_1_1_receive_is_header, Noc_1_1_receive_is_tail,
                                 Noc_1_1_receive_flit};

  assign out_ready[NODE_ID_0_0] = Noc_0_0_sender_ready;
  assign out_ready[NODE_ID_0_1] = Noc_0_1_sender_ready;
  assign out_ready[NODE_ID_1_0] = Noc_1_0_sender_ready;
  assign out_ready[NODE_ID_1_1] = Noc_1_1_sender_ready;

  assign Noc_0_0_receive_ready    = in_ready[NODE_ID_0_0];
  assign Noc_0_1_receive_ready    = in_ready[NODE_ID_0_1];
  assign Noc_1_0_receive_ready    = in_ready[NODE_ID_1_0];
  assign Noc_1_1_receive_ready    = in_ready[NODE_ID_1_1];

  assign Noc_0_0_sender_valid     = out_valid[NODE_ID_0_0];
  assign Noc_0_0_sender_flit      = out_flit[NODE_ID_0_0].data;
  assign Noc_0_0_sender_is_header = out_flit[NODE_ID_0_0].is_header;
  assign Noc_0_0_sender_is_tail   = out_flit[NODE_ID_0_0].is_tail;
  assign Noc_0_1_sender_valid     = out_valid[NODE_ID_0_1];
  assign Noc_0_1_sender_flit      = out_flit[NODE_ID_0_1].data;
  assign Noc_0_1_sender_is_header = out_flit[NODE_ID_0_1].is_header;
  assign Noc_0_1_sender_is_tail   = out_flit[NODE_ID_0_1].is_tail;
  assign Noc_1_0_sender_valid     = out_valid[NODE_ID_1_0];
  assign Noc_1_0_sender_flit      = out_flit[NODE_ID_1_0].data;
  assign Noc_1_0_sender_is_header = out_flit[NODE_ID_1_0].is_header;
  assign Noc_1_0_sender_is_tail   = out_flit[NODE_ID_1_0].is_tail;
  assign Noc_1_1_sender_valid     = out_valid[NODE_ID_1_1];
  assign Noc_1_1_sender_flit      = out_flit[NODE_ID_1_1].data;
  assign Noc_1_1_sender_is_header = out_flit[NODE_ID_1_1].is_header;
  assign Noc_1_1_sender_is_tail   = out_flit[NODE_ID_1_1].is_tail;

  // ---- ingress FIFOs ----
  for (genvar i = 0; i < NOC_NODES; i++) begin : g_fifo
    noc_flit_fifo #(
      .WIDTH(FW),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (noc_clk),
      .rst_n(noc_rst_n),
      .push (in_valid[i] && in_ready[i]),
      .wdata(in_flit[i]),
      .full (in_full[i]),
      .pop  (in_pop[i]),
      .rdata(head[i]),
      .empty(in_empty[i])
    );
  end

  // Holds receive_ready low while reset is asserted, high from the first edge after.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) alive_q <= 1'b0;
    else            alive_q <= 1'b1;
  end

  assign in_ready = {NOC_NODES{alive_q}} & ~in_full;
  assign hs       = out_valid & out_ready;

  // Mark inputs currently owned by a locked output.
  always_comb begin
    bound = '0;
    for (int o = 0; o < NOC_NODES; o++) begin
      if (state_q[o] == StLocked) bound[owner_q[o]] = 1'b1;
    end
  end

  // Per-output candidate set and round-robin pick starting at rr_q.
  always_comb begin
    grant_valid = '0;
    for (int o = 0; o < NOC_NODES; o++) begin
      grant_idx[o] = '0;
      for (int i = 0; i < NOC_NODES; i++) begin
        req[o][i] = !in_empty[i] && head[i].is_header && !bound[i] &&
                    (head[i].data[DEST_LSB +: DEST_W] == DEST_W'(o));
      end
      for (int k = 0; k < NOC_NODES; k++) begin
        if (!grant_valid[o] && req[o][rr_q[o] + DEST_W'(k)]) begin
          grant_valid[o] = 1'b1;
          grant_idx[o]   = rr_q[o] + DEST_W'(k);
        end
      end
    end
  end

  // Egress drive from the owner FIFO head; zero whenever nothing is offered.
  always_comb begin
    out_valid = '0;
    for (int o = 0; o < NOC_NODES; o++) begin
      out_flit[o] = '0;
      if (state_q[o] == StLocked && !in_empty[owner_q[o]]) begin
        out_valid[o] = 1'b1;
        out_flit[o]  = head[owner_q[o]];
      end
    end
  end

  // Pop on egress handshake, or drop an orphan body flit at an unbound input.
  always_comb begin
    for (int i = 0; i < NOC_NODES; i++) begin
      in_pop[i] = !in_empty[i] && !bound[i] && !head[i].is_header;
    end
    for (int o = 0; o < NOC_NODES; o++) begin
      if (hs[o]) in_pop[owner_q[o]] = 1'b1;
    end
  end

  // Output lock FSM: IDLE grabs the RR winner, LOCKED releases after the tail.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int o = 0; o < NOC_NODES; o++) begin
        state_q[o] <= StIdle;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < NOC_NODES; o++) begin
        unique case (state_q[o])
          StIdle: begin
            if (grant_valid[o]) begin
              state_q[o] <= StLocked;
              owner_q[o] <= grant_idx[o];
              rr_q[o]    <= rr_next(grant_idx[o]);
            end
          end
          StLocked: begin
            if (hs[o] && out_flit[o].is_tail) state_q[o] <= StIdle;
          end
          default: state_q[o] <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_connector.sv
// Directed bench for noc_connector: latency, bursts, contention,
// backpressure, concurrency and mid-packet reset.
module tb_noc_connector;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        rx_valid [4];
  logic        rx_ready [4];
  logic [31:0] rx_flit  [4];
  logic        rx_hdr   [4];
  logic        rx_tail  [4];
  logic        tx_valid [4];
  logic        tx_ready [4];
  logic [31:0] tx_flit  [4];
  logic        tx_hdr   [4];
  logic        tx_tail  [4];

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [35:0] got [$];      // {port, hdr, tail, flit}
  int          got_cyc [$];
  logic [33:0] exp_q [$];    // {hdr, tail, flit}

  always #5 noc_clk = ~noc_clk;

  noc_connector #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .noc_clk                 (noc_clk),
    .noc_rst_n               (noc_rst_n),
    .Noc_0_0_receive_valid   (rx_valid[0]),
    .Noc_0_0_receive_ready   (rx_ready[0]),
    .Noc_0_0_receive_flit    (rx_flit[0]),
    .Noc_0_0_receive_is_header(rx_hdr[0]),
    .Noc_0_0_receive_is_tail (rx_tail[0]),
    .Noc_0_0_sender_valid    (tx_valid[0]),
    .Noc_0_0_sender_ready    (tx_ready[0]),
    .Noc_0_0_sender_flit     (tx_flit[0]),
    .Noc_0_0_sender_is_header(tx_hdr[0]),
    .Noc_0_0_sender_is_tail  (tx_tail[0]),
    .Noc_0_1_receive_valid   (rx_valid[1]),
    .Noc_0_1_receive_ready   (rx_ready[1]),
    .Noc_0_1_receive_flit    (rx_flit[1]),
    .Noc_0_1_receive_is_header(rx_hdr[1]),
    .Noc_0_1_receive_is_tail (rx_tail[1]),
    .Noc_0_1_sender_valid    (tx_valid[1]),
    .Noc_0_1_sender_ready    (tx_ready[1]),
    .Noc_0_1_sender_flit     (tx_flit[1]),
    .Noc_0_1_sender_is_header(tx_hdr[1]),
    .Noc_0_1_sender_is_tail  (tx_tail[1]),
    .Noc_1_0_receive_valid   (rx_valid[2]),
    .Noc_1_0_receive_ready   (rx_ready[2]),
    .Noc_1_0_receive_flit    (rx_flit[2]),
    .Noc_1_0_receive_is_header(rx_hdr[2]),
    .Noc_1_0_receive_is_tail (rx_tail[2]),
    .Noc_1_0_sender_valid    (tx_valid[2]),
    .Noc_1_0_sender_ready    (tx_ready[2]),
    .Noc_1_0_sender_flit     (tx_flit[2]),
    .Noc_1_0_sender_is_header(tx_hdr[2]),
    .Noc_1_0_sender_is_tail  (tx_tail[2]),
    .Noc_1_1_receive_valid   (rx_valid[3]),
    .Noc_1_1_receive_ready   (rx_ready[3]),
    .Noc_1_1_receive_flit    (rx_flit[3]),
    .Noc_1_1_receive_is_header(rx_hdr[3]),
    .Noc_1_1_receive_is_tail (rx_tail[3]),
    .Noc_1_1_sender_valid    (tx_valid[3]),
    .Noc_1_1_sender_ready    (tx_ready[3]),
    .Noc_1_1_sender_flit     (tx_flit[3]),
    .Noc_1_1_sender_is_header(tx_hdr[3]),
    .Noc_1_1_sender_is_tail  (tx_tail[3])
  );

  always @(posedge noc_clk) cyc <= cyc + 1;

  // Egress monitor: inputs only change just after posedge, so the negedge
  // view of valid && ready is exactly what transfers at the next edge.
  always @(negedge noc_clk) begin
    for (int p = 0; p < 4; p++) begin
      if (tx_valid[p] && tx_ready[p]) begin
        got.push_back({2'(p), tx_hdr[p], tx_tail[p], tx_flit[p]});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vbits();
    return {tx_valid[3], tx_valid[2], tx_valid[1], tx_valid[0]};
  endfunction

  function automatic logic [3:0] rbits();
    return {rx_ready[3], rx_ready[2], rx_ready[1], rx_ready[0]};
  endfunction

  // Flit k of a packet: header word first, then base + k*0x11.
  function automatic logic [33:0] pkt_flit(input logic [31:0] hdr, input int len,
                                           input int base, input int k);
    logic [31:0] w;
    w = (k == 0) ? hdr : 32'(base + k * 'h11);
    return {k == 0, k == len - 1, w};
  endfunction

  task automatic push_flit(input int n, input logic [31:0] f, input logic h, input logic t);
    int waited;
    waited = 0;
    rx_valid[n] = 1'b1;
    rx_flit[n]  = f;
    rx_hdr[n]   = h;
    rx_tail[n]  = t;
    forever begin
      @(negedge noc_clk);
      if (rx_ready[n]) break;
      waited = waited + 1;
      if (waited > 200) begin
        check("push_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge noc_clk);
    #1;
    rx_valid[n] = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] hdr, input int len, input int base);
    logic [33:0] f;
    for (int k = 0; k < len; k++) begin
      f = pkt_flit(hdr, len, base, k);
      push_flit(n, f[31:0], f[33], f[32]);
    end
  endtask

  task automatic add_exp(input logic [31:0] hdr, input int len, input int base);
    for (int k = 0; k < len; k++) exp_q.push_back(pkt_flit(hdr, len, base, k));
  endtask

  // Compare everything delivered on port p against exp_q, optionally
  // requiring the flits to arrive on consecutive cycles.
  task automatic check_port(input string tag, input int p, input bit contiguous);
    logic [33:0] seen [$];
    int          cy [$];
    foreach (got[j]) begin
      if (got[j][35:34] == 2'(p)) begin
        seen.push_back(got[j][33:0]);
        cy.push_back(got_cyc[j]);
      end
    end
    check({tag, "_count"}, 64'(seen.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < seen.size(); j++)
      check($sformatf("%s_flit%0d", tag, j), 64'(seen[j]), 64'(exp_q[j]));
    if (contiguous && seen.size() > 0)
      check({tag, "_stream"}, 64'(cy[cy.size()-1] - cy[0]), 64'(seen.size() - 1));
    exp_q.delete();
  endtask

  task automatic clear_got();
    got.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    repeat (3) @(posedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rx_valid[i] = 1'b0;
      rx_flit[i]  = '0;
      rx_hdr[i]   = 1'b0;
      rx_tail[i]  = 1'b0;
      tx_ready[i] = 1'b1;
    end

    // Reset state
    repeat (2) @(posedge noc_clk);
    #1;
    check("rst_sender_valid", 64'(vbits()), 64'(0));
    check("rst_receive_ready", 64'(rbits()), 64'(0));
    check("rst_sender_flit", 64'(tx_flit[3]), 64'(0));
    check("rst_sender_flags", 64'({tx_hdr[3], tx_tail[3]}), 64'(0));
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
    check("rel_receive_ready", 64'(rbits()), 64'(4'hf));

    // Single-flit 0_0 -> 1_1: accepted at edge N, valid only after N+1
    clear_got();
    rx_valid[0] = 1'b1;
    rx_flit[0]  = 32'h0000_AB03;
    rx_hdr[0]   = 1'b1;
    rx_tail[0]  = 1'b1;
    @(negedge noc_clk);
    check("single_ready", 64'(rx_ready[0]), 64'(1));
    @(posedge noc_clk);
    #1;
    rx_valid[0] = 1'b0;
    @(negedge noc_clk);
    check("single_bubble", 64'(vbits()), 64'(4'b0000));
    @(negedge noc_clk);
    check("single_valid", 64'(vbits()), 64'(4'b1000));
    check("single_flit", 64'(tx_flit[3]), 64'(32'h0000_AB03));
    check("single_flags", 64'({tx_hdr[3], tx_tail[3]}), 64'(2'b11));
    repeat (5) @(posedge noc_clk);
    #1;
    check("single_total", 64'(got.size()), 64'(1));
    add_exp(32'h0000_AB03, 1, 0);
    check_port("single", 3, 1'b0);

    // 4-flit 0_1 -> 1_0 streams on consecutive cycles
    clear_got();
    send_pkt(1, 32'h5A5A_0002, 4, 0);
    repeat (10) @(posedge noc_clk);
    #1;
    add_exp(32'h5A5A_0002, 4, 0);
    check_port("burst", 2, 1'b1);

    // Contention on 1_1 from a fresh RR pointer: 0_0 wins first
    do_reset();
    clear_got();
    fork
      send_pkt(0, 32'h0000_A003, 3, 'h1000);
      send_pkt(1, 32'h0000_B003, 3, 'h2000);
    join
    repeat (15) @(posedge noc_clk);
    #1;
    add_exp(32'h0000_A003, 3, 'h1000);
    add_exp(32'h0000_B003, 3, 'h2000);
    check_port("contend1", 3, 1'b0);

    // Backpressure: 8-flit 0_0 -> 1_1 with the sink stalled
    clear_got();
    tx_ready[3] = 1'b0;
    fork
      send_pkt(0, 32'h0000_C003, 8, 'h3000);
      begin
        repeat (3) @(posedge noc_clk);
        @(negedge noc_clk);
        check("bp_ready_3", 64'(rx_ready[0]), 64'(1));
        @(negedge noc_clk);
        check("bp_ready_full", 64'(rx_ready[0]), 64'(0));
        repeat (6) @(negedge noc_clk);
        check("bp_hold_valid", 64'(tx_valid[3]), 64'(1));
        check("bp_hold_flit", 64'({tx_hdr[3], tx_tail[3], tx_flit[3]}),
              64'({2'b10, 32'h0000_C003}));
        @(posedge noc_clk);
        #1;
        tx_ready[3] = 1'b1;
      end
    join
    repeat (10) @(posedge noc_clk);
    #1;
    add_exp(32'h0000_C003, 8, 'h3000);
    check_port("bp", 3, 1'b0);

    // Contention again: pointer now sits after 0_0, so 0_1 goes first
    clear_got();
    fork
      send_pkt(0, 32'h0000_A103, 3, 'h1100);
      send_pkt(1, 32'h0000_B103, 3, 'h2100);
    join
    repeat (15) @(posedge noc_clk);
    #1;
    add_exp(32'h0000_B103, 3, 'h2100);
    add_exp(32'h0000_A103, 3, 'h1100);
    check_port("contend2", 3, 1'b0);

    // Concurrent 0_0 -> 1_0 and 0_1 -> 1_1 at full rate
    clear_got();
    fork
      send_pkt(0, 32'h0000_F002, 6, 'h6000);
      send_pkt(1, 32'h0000_F103, 6, 'h7000);
    join
    repeat (10) @(posedge noc_clk);
    #1;
    add_exp(32'h0000_F002, 6, 'h6000);
    check_port("conc_a", 2, 1'b1);
    add_exp(32'h0000_F103, 6, 'h7000);
    check_port("conc_b", 3, 1'b1);

    // Reset after 2 of 4 flits of 1_0 -> 0_0
    clear_got();
    tx_ready[0] = 1'b0;
    push_flit(2, 32'h0000_D000, 1'b1, 1'b0);
    push_flit(2, 32'h0000_4001, 1'b0, 1'b0);
    check("mid_valid", 64'(tx_valid[0]), 64'(1));
    noc_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(vbits()), 64'(0));
    check("mid_rst_flit", 64'({tx_hdr[0], tx_tail[0], tx_flit[0]}), 64'(0));
    check("mid_rst_ready", 64'(rbits()), 64'(0));
    repeat (2) @(posedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
    check("mid_rel_ready", 64'(rbits()), 64'(4'hf));
    tx_ready[0] = 1'b1;
    clear_got();
    push_flit(2, 32'h0000_4002, 1'b0, 1'b0);
    push_flit(2, 32'h0000_4003, 1'b0, 1'b1);
    send_pkt(2, 32'h0000_E000, 3, 'h5000);
    repeat (10) @(posedge noc_clk);
    #1;
    check("post_rst_total", 64'(got.size()), 64'(3));
    add_exp(32'h0000_E000, 3, 'h5000);
    check_port("post_rst", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
